// File: rtl/guess_hand_pkg.sv
// rtl/guess_hand_pkg.sv - shared types, command bytes and helpers for the guess-hand controller
package guess_hand_pkg;

  typedef enum logic [1:0] {H_NONE = 2'd0, H_ROCK = 2'd1, H_SCIS = 2'd2, H_PAPER = 2'd3} hand_t;
  typedef enum logic [1:0] {R_NONE = 2'd0, R_WIN = 2'd1, R_LOSE = 2'd2, R_DRAW = 2'd3} result_t;
  typedef enum logic [1:0] {S_WAIT = 2'd0, S_SHOW = 2'd1, S_OVER = 2'd2} state_t;

  localparam logic [7:0]  CMD_ROCK  = 8'h52;
  localparam logic [7:0]  CMD_SCIS  = 8'h53;
  localparam logic [7:0]  CMD_PAPER = 8'h50;
  localparam logic [7:0]  CMD_NEW   = 8'h4E;
  localparam logic [7:0]  CASE_BIT  = 8'h20;
  // Galois mask for taps 16,14,13,11 on a right-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic result_t judge(hand_t p, hand_t c);
    if (p == c) return R_DRAW;
    if ((p == H_ROCK && c == H_SCIS) || (p == H_SCIS && c == H_PAPER) ||
        (p == H_PAPER && c == H_ROCK)) return R_WIN;
    return R_LOSE;
  endfunction

  function automatic longint ms2cyc(longint ms, longint clk_fre);
    return clk_fre * 1000 * ms;
  endfunction

  function automatic logic [7:0] to_upper(logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b & ~CASE_BIT;
    return b;
  endfunction

endpackage

// File: rtl/gh_ms_timer.sv
// rtl/gh_ms_timer.sv - loadable down-counter; done_o is high in the last counted cycle
module gh_ms_timer #(
  parameter longint MAX_CYC = 1000,
  parameter int     W       = $clog2(MAX_CYC + 1)
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o,
  output logic         busy_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)              cnt_d = '0;
    else if (load_i)        cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == W'(1));
  assign busy_o = |cnt_q;

endmodule

// File: rtl/guess_hand_ctrl.sv
// rtl/guess_hand_ctrl.sv - rock/paper/scissors controller; GUESS_HAND_TIMEOUT_EN adds idle forfeit
import guess_hand_pkg::*;

module guess_hand_ctrl #(
  parameter int          CLK_FRE    = 50,
  parameter int          SHOW_MS    = 1000,
  parameter int          WIN_SCORE  = 3,
  parameter int          SCORE_W    = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          TIMEOUT_MS = 5000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_data_valid,
  output logic               show,
  output logic [3:0]         hand,
  output logic [SCORE_W-1:0] score_p,
  output logic [SCORE_W-1:0] score_c,
  output logic [7:0]         round_cnt,
  output logic [1:0]         result,
  output logic               game_over,
  output logic               cmd_err
);

  localparam longint SHOW_CYC = ms2cyc(SHOW_MS, CLK_FRE);
  localparam longint TO_CYC   = ms2cyc(TIMEOUT_MS, CLK_FRE);
  localparam longint MAX_CYC  = (SHOW_CYC > TO_CYC) ? SHOW_CYC : TO_CYC;
  localparam int     TW       = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0]      SHOW_LOAD = TW'(SHOW_CYC);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
`ifdef GUESS_HAND_TIMEOUT_EN
  localparam logic [TW-1:0]      TO_LOAD   = TW'(TO_CYC);
`endif

  state_t               state_q, state_d;
  result_t              result_q, result_d;
  logic [3:0]           hand_q, hand_d;
  logic [SCORE_W-1:0]   score_p_q, score_p_d, score_c_q, score_c_d;
  logic [7:0]           round_q, round_d;
  logic                 show_q, show_d, over_q, over_d, err_q, err_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [1:0]           m3_q, m3_d;
  logic                 tmr_clr, tmr_load, tmr_done, tmr_busy;
  logic [TW-1:0]        tmr_val;

  logic [7:0] cmd;
  hand_t      p_move, c_move;
  result_t    rnd_res;
  logic       is_new, is_move;

  assign cmd     = to_upper(rx_data);
  assign c_move  = hand_t'(m3_q + 2'd1);
  assign rnd_res = judge(p_move, c_move);
  assign is_new  = rx_data_valid && (cmd == CMD_NEW);
  assign is_move = rx_data_valid && (p_move != H_NONE);

  always_comb begin
    case (cmd)
      CMD_ROCK:  p_move = H_ROCK;
      CMD_SCIS:  p_move = H_SCIS;
      CMD_PAPER: p_move = H_PAPER;
      default:   p_move = H_NONE;
    endcase
  end

  // CPU move source: free-running LFSR gating a mod-3 counter
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  assign m3_d   = lfsr_q[0] ? ((m3_q == 2'd2) ? 2'd0 : m3_q + 2'd1) : m3_q;

  gh_ms_timer #(.MAX_CYC(MAX_CYC), .W(TW)) u_timer (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done),
    .busy_o     (tmr_busy)
  );

  always_comb begin
    state_d   = state_q;
    hand_d    = hand_q;
    result_d  = result_q;
    score_p_d = score_p_q;
    score_c_d = score_c_q;
    round_d   = round_q;
    show_d    = show_q;
    over_d    = over_q;
    err_d     = rx_data_valid && !is_new && (!is_move || state_q != S_WAIT);
    tmr_clr   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = SHOW_LOAD;
    if (is_new) begin
      state_d   = S_WAIT;
      hand_d    = '0;
      result_d  = R_NONE;
      score_p_d = '0;
      score_c_d = '0;
      round_d   = '0;
      show_d    = 1'b0;
      over_d    = 1'b0;
      tmr_clr   = tmr_busy;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (is_move) begin
            hand_d   = {c_move, p_move};
            result_d = rnd_res;
            if (rnd_res == R_WIN && score_p_q < WIN)  score_p_d = score_p_q + 1'b1;
            if (rnd_res == R_LOSE && score_c_q < WIN) score_c_d = score_c_q + 1'b1;
            round_d  = round_q + 8'd1;
            show_d   = 1'b1;
            tmr_load = 1'b1;
            state_d  = S_SHOW;
          end
`ifdef GUESS_HAND_TIMEOUT_EN
          else if (tmr_done) begin
            hand_d   = {c_move, H_NONE};
            result_d = R_LOSE;
            if (score_c_q < WIN) score_c_d = score_c_q + 1'b1;
            round_d  = round_q + 8'd1;
            show_d   = 1'b1;
            tmr_load = 1'b1;
            state_d  = S_SHOW;
          end else if (!tmr_busy) begin
            tmr_load = 1'b1;
            tmr_val  = TO_LOAD;
          end
`endif
        end
        S_SHOW: begin
          if (tmr_done) begin
            if (score_p_q == WIN || score_c_q == WIN) begin
              over_d  = 1'b1;
              state_d = S_OVER;
            end else begin
              show_d  = 1'b0;
              hand_d  = '0;
              state_d = S_WAIT;
            end
          end
        end
        S_OVER:  ;
        default: state_d = S_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_WAIT;
      hand_q    <= '0;
      result_q  <= R_NONE;
      score_p_q <= '0;
      score_c_q <= '0;
      round_q   <= '0;
      show_q    <= 1'b0;
      over_q    <= 1'b0;
      err_q     <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      m3_q      <= '0;
    end else begin
      state_q   <= state_d;
      hand_q    <= hand_d;
      result_q  <= result_d;
      score_p_q <= score_p_d;
      score_c_q <= score_c_d;
      round_q   <= round_d;
      show_q    <= show_d;
      over_q    <= over_d;
      err_q     <= err_d;
      lfsr_q    <= lfsr_d;
      m3_q      <= m3_d;
    end
  end

  assign show      = show_q;
  assign hand      = hand_q;
  assign score_p   = score_p_q;
  assign score_c   = score_c_q;
  assign round_cnt = round_q;
  assign result    = result_q;
  assign game_over = over_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_guess_hand_ctrl.sv
// tb/tb_guess_hand_ctrl.sv - directed self-checking bench for guess_hand_ctrl
module tb_guess_hand_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_valid = 1'b0;
  logic       show, game_over, cmd_err;
  logic [3:0] hand, score_p, score_c;
  logic [7:0] round_cnt;
  logic [1:0] result;

  int checks = 0;
  int failures = 0;

  logic [15:0] lfsr_m;
  logic [1:0]  m3_m;
  logic [3:0]  exp_hand, exp_sp, exp_sc;
  logic [7:0]  exp_rnd;
  logic [1:0]  exp_res;

  wire [24:0] outs = {show, hand, score_p, score_c, round_cnt, result, game_over, cmd_err};

  guess_hand_ctrl #(
    .CLK_FRE(1), .SHOW_MS(1), .WIN_SCORE(3), .SCORE_W(4),
    .LFSR_SEED(16'hACE1), .TIMEOUT_MS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .show(show), .hand(hand), .score_p(score_p), .score_c(score_c),
    .round_cnt(round_cnt), .result(result), .game_over(game_over), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Reference CPU-move generator
  always @(posedge clk) begin
    if (!rst_n) begin
      lfsr_m <= 16'hACE1;
      m3_m   <= 2'd0;
    end else begin
      lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
      if (lfsr_m[0]) m3_m <= (m3_m == 2'd2) ? 2'd0 : m3_m + 2'd1;
    end
  end

  function automatic logic [24:0] vec(logic s, logic [3:0] h, logic [3:0] sp, logic [3:0] sc,
                                      logic [7:0] r, logic [1:0] res, logic ov, logic er);
    return {s, h, sp, sc, r, res, ov, er};
  endfunction

  function automatic logic [1:0] beats(logic [1:0] c);
    case (c)
      2'd1:    return 2'd3;
      2'd2:    return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [7:0] char_of(logic [1:0] h);
    case (h)
      2'd1:    return 8'h52;
      2'd2:    return 8'h53;
      default: return 8'h50;
    endcase
  endfunction

  function automatic logic [1:0] judge_m(logic [1:0] p, logic [1:0] c);
    if (p == c) return 2'd3;
    if (beats(c) == p) return 2'd1;
    return 2'd2;
  endfunction

  task clear_exp();
    exp_hand = 4'd0; exp_sp = 4'd0; exp_sc = 4'd0; exp_rnd = 8'd0; exp_res = 2'd0;
  endtask

  task send(input logic [7:0] b);
    rx_data = b;
    rx_data_valid = 1'b1;
    @(negedge clk);
    rx_data_valid = 1'b0;
    rx_data = 8'h00;
  endtask

  // p_force == 0 picks the move that beats the predicted CPU move
  task play(input logic [1:0] p_force, input logic lower);
    logic [1:0] cpu, p, res;
    cpu = m3_m + 2'd1;
    p = (p_force == 2'd0) ? beats(cpu) : p_force;
    send(char_of(p) | (lower ? 8'h20 : 8'h00));
    res = judge_m(p, cpu);
    exp_hand = {cpu, p};
    exp_res = res;
    if (res == 2'd1 && exp_sp < 4'd3) exp_sp = exp_sp + 4'd1;
    if (res == 2'd2 && exp_sc < 4'd3) exp_sc = exp_sc + 4'd1;
    exp_rnd = exp_rnd + 8'd1;
    checks++;
    if (outs !== vec(1'b1, exp_hand, exp_sp, exp_sc, exp_rnd, exp_res, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL round_accept: got %h expected %h", outs,
               vec(1'b1, exp_hand, exp_sp, exp_sc, exp_rnd, exp_res, 1'b0, 1'b0));
    end
  endtask

  task wait_out(input int used, input logic to_over);
    repeat (999 - used) @(negedge clk);
    checks++;
    if (show !== 1'b1) begin
      failures++;
      $display("FAIL show_hold: got show=%b expected 1", show);
    end
    @(negedge clk);
    if (!to_over) exp_hand = 4'd0;
    checks++;
    if (outs !== vec(to_over, exp_hand, exp_sp, exp_sc, exp_rnd, exp_res, to_over, 1'b0)) begin
      failures++;
      $display("FAIL show_expiry: got %h expected %h", outs,
               vec(to_over, exp_hand, exp_sp, exp_sc, exp_rnd, exp_res, to_over, 1'b0));
    end
  endtask

  task test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== 25'd0 || dut.lfsr_q !== 16'hACE1) begin
      failures++;
      $display("FAIL reset_state: got outs=%h lfsr=%h expected 0 and ace1", outs, dut.lfsr_q);
    end
    rst_n = 1'b1;
    clear_exp();
  endtask

  task test_round_win();
    for (int i = 0; i < 300 && m3_m != 2'd1; i++) @(negedge clk);
    checks++;
    if (m3_m !== 2'd1) begin
      failures++;
      $display("FAIL cpu_wait: got m3=%0d expected 1", m3_m);
    end
    play(2'd1, 1'b1);
    checks++;
    if (hand !== 4'b1001) begin
      failures++;
      $display("FAIL hand_rock_vs_scis: got %b expected 1001", hand);
    end
    wait_out(0, 1'b0);
  endtask

  task test_reset_mid();
    play(2'd0, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 25'd0 || dut.lfsr_q !== 16'hACE1) begin
      failures++;
      $display("FAIL reset_mid_show: got outs=%h lfsr=%h expected 0 and ace1", outs, dut.lfsr_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_exp();
  endtask

  task test_illegal();
    send(8'h58);
    checks++;
    if (outs !== vec(1'b0, 4'd0, 4'd0, 4'd0, 8'd0, 2'd0, 1'b0, 1'b1)) begin
      failures++;
      $display("FAIL illegal_wait: got %h expected 0000001", outs);
    end
    @(negedge clk);
    checks++;
    if (outs !== 25'd0) begin
      failures++;
      $display("FAIL illegal_pulse_width: got %h expected 0", outs);
    end
    play(2'd0, 1'b0);
    send(8'h50);
    checks++;
    if (outs !== vec(1'b1, exp_hand, exp_sp, exp_sc, exp_rnd, exp_res, 1'b0, 1'b1)) begin
      failures++;
      $display("FAIL move_in_show: got %h expected %h", outs,
               vec(1'b1, exp_hand, exp_sp, exp_sc, exp_rnd, exp_res, 1'b0, 1'b1));
    end
    wait_out(1, 1'b0);
  endtask

  task test_back_to_back();
    rx_data = 8'h78;
    rx_data_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (cmd_err !== 1'b1) begin
        failures++;
        $display("FAIL held_valid_err: got %b expected 1", cmd_err);
      end
    end
    rx_data_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== vec(1'b0, 4'd0, exp_sp, exp_sc, exp_rnd, exp_res, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL held_valid_release: got %h", outs);
    end
  endtask

  task test_game_over();
    send(8'h4E);
    clear_exp();
    checks++;
    if (outs !== 25'd0) begin
      failures++;
      $display("FAIL new_game_clear: got %h expected 0", outs);
    end
    play(2'd0, 1'b0);
    wait_out(0, 1'b0);
    play(2'd0, 1'b1);
    wait_out(0, 1'b0);
    play(2'd0, 1'b0);
    wait_out(0, 1'b1);
    send(8'h53);
    checks++;
    if (outs !== vec(1'b1, exp_hand, 4'd3, exp_sc, 8'd3, 2'd1, 1'b1, 1'b1)) begin
      failures++;
      $display("FAIL move_in_over: got %h", outs);
    end
    send(8'h6E);
    clear_exp();
    checks++;
    if (outs !== 25'd0) begin
      failures++;
      $display("FAIL new_from_over: got %h expected 0", outs);
    end
    play(2'd1, 1'b0);
    wait_out(0, 1'b0);
  endtask

  task test_n_on_expiry();
    send(8'h4E);
    clear_exp();
    play(2'd0, 1'b0);
    wait_out(0, 1'b0);
    play(2'd0, 1'b0);
    wait_out(0, 1'b0);
    play(2'd0, 1'b0);
    repeat (999) @(negedge clk);
    send(8'h4E);
    clear_exp();
    checks++;
    if (outs !== 25'd0) begin
      failures++;
      $display("FAIL new_on_expiry: got %h expected 0", outs);
    end
    play(2'd1, 1'b1);
    wait_out(0, 1'b0);
  endtask

  task test_idle();
`ifdef GUESS_HAND_TIMEOUT_EN
    logic [1:0] cpu;
    cpu = 2'd0;
    for (int i = 0; i < 2300 && !show; i++) begin
      cpu = m3_m + 2'd1;
      @(negedge clk);
    end
    exp_hand = {cpu, 2'd0};
    exp_res = 2'd2;
    exp_sc = exp_sc + 4'd1;
    exp_rnd = exp_rnd + 8'd1;
    checks++;
    if (outs !== vec(1'b1, exp_hand, exp_sp, exp_sc, exp_rnd, exp_res, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL idle_forfeit: got %h expected %h", outs,
               vec(1'b1, exp_hand, exp_sp, exp_sc, exp_rnd, exp_res, 1'b0, 1'b0));
    end
`else
    repeat (10000) @(negedge clk);
    checks++;
    if (outs !== vec(1'b0, 4'd0, exp_sp, exp_sc, exp_rnd, exp_res, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL idle_no_change: got %h expected %h", outs,
               vec(1'b0, 4'd0, exp_sp, exp_sc, exp_rnd, exp_res, 1'b0, 1'b0));
    end
`endif
  endtask

  initial begin
    clear_exp();
    test_reset();
    test_round_win();
    test_reset_mid();
    test_illegal();
    test_back_to_back();
    test_game_over();
    test_n_on_expiry();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
